// File: rtl/arb_mux_if.sv
// Handshake bundle for arb_mux: N competing sources in, one registered sink out.
// The master side drives sources and sink-ready; the slave side is the selector.
interface arb_mux_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               force_en;
    logic [SEL_W-1:0]   force_sel;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, force_en, force_sel, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_valid, force_en, force_sel, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/arb_mux.sv
// N-input arbitrated selector with a registered output stage.
// Fixed-priority or round-robin grant, with an external select override.
module arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int RR    = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    arb_mux_if.slave bus
);
    localparam int SEL_W = $clog2(N);

    logic             can_load;
    logic             xfer;
    logic [N-1:0]     elig;
    logic [N-1:0]     grant;
    logic [N-1:0]     ready;
    logic [SEL_W-1:0] gidx;
    logic [SEL_W-1:0] base;
    logic [SEL_W-1:0] ptr;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] sel_q;
    logic             valid_q;

    always_comb can_load = !valid_q || bus.out_ready;

    // An out-of-range force_sel matches no channel, so nothing is eligible.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = bus.in_valid[i] &&
                      (!bus.force_en || bus.force_sel == SEL_W'(i));
        end
    end

    always_comb base = (RR != 0) ? ptr : '0;

    // Scan from the farthest candidate back to base so the nearest one wins.
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        gidx  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(base) + k;
            if (j >= N) j = j - N;
            if (elig[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                gidx     = SEL_W'(j);
            end
        end
    end

    always_comb begin
        ready = grant & {N{can_load & rst_n}};
        xfer  = |ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr     <= '0;
        end else if (xfer) begin
            data_q  <= bus.in_data[int'(gidx)*WIDTH +: WIDTH];
            sel_q   <= gidx;
            valid_q <= 1'b1;
            if (RR != 0 && !bus.force_en) begin
                ptr <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
            end
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: a fixed-priority and a round-robin instance share stimulus
// and are checked against a per-cycle arbitration model.
module tb_arb_mux;
    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arb_mux_if #(.WIDTH(W), .N(N)) if_fp ();
    arb_mux_if #(.WIDTH(W), .N(N)) if_rr ();

    arb_mux #(.WIDTH(W), .N(N), .RR(0)) u_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_fp.slave)
    );

    arb_mux #(.WIDTH(W), .N(N), .RR(1)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_rr.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [N*W-1:0] din;
    logic           m_valid [2];
    logic [W-1:0]   m_data  [2];
    int             m_sel   [2];
    int             m_ptr;
    string          nm [2] = '{"fp", "rr"};

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Spec rule: first eligible channel searching upward from base, wrapping.
    function automatic int pick(input logic [3:0] v, input logic fen,
                                input logic [1:0] fs, input int base);
        for (int k = 0; k < N; k++) begin
            int c = (base + k) % N;
            if (v[c] && (!fen || int'(fs) == c)) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_sel[d]   = 0;
        end
        m_ptr = 0;
    endtask

    // One cycle: drive at negedge, check grants, advance model at posedge,
    // check the registered outputs at the following negedge.
    task automatic step(input logic [3:0] iv, input logic fen,
                        input logic [1:0] fs, input logic ordy);
        int          w   [2];
        logic [3:0]  rdy [2];
        logic        ov  [2];
        logic [31:0] od  [2];
        logic [1:0]  os  [2];
        logic        can;
        if_fp.in_data = din;  if_rr.in_data = din;
        if_fp.in_valid = iv;  if_rr.in_valid = iv;
        if_fp.force_en = fen; if_rr.force_en = fen;
        if_fp.force_sel = fs; if_rr.force_sel = fs;
        if_fp.out_ready = ordy; if_rr.out_ready = ordy;
        #1;
        rdy[0] = if_fp.in_ready;
        rdy[1] = if_rr.in_ready;
        for (int d = 0; d < 2; d++) begin
            can  = !m_valid[d] || ordy;
            w[d] = (can && rst_n) ? pick(iv, fen, fs, d == 1 ? m_ptr : 0) : -1;
            check({nm[d], "_in_ready"}, 64'(rdy[d]),
                  w[d] >= 0 ? 64'(4'b0001 << w[d]) : 64'd0);
        end
        @(posedge clk);
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (w[d] >= 0) begin
                    m_valid[d] = 1'b1;
                    m_data[d]  = din[w[d]*W +: W];
                    m_sel[d]   = w[d];
                    if (d == 1 && !fen) m_ptr = (w[d] + 1) % N;
                end else if (ordy) begin
                    m_valid[d] = 1'b0;
                end
            end
        end
        @(negedge clk);
        ov[0] = if_fp.out_valid; od[0] = if_fp.out_data; os[0] = if_fp.out_sel;
        ov[1] = if_rr.out_valid; od[1] = if_rr.out_data; os[1] = if_rr.out_sel;
        for (int d = 0; d < 2; d++) begin
            check({nm[d], "_out_valid"}, 64'(ov[d]), 64'(m_valid[d]));
            check({nm[d], "_out_data"}, 64'(od[d]), 64'(m_data[d]));
            check({nm[d], "_out_sel"}, 64'(os[d]), 64'(m_sel[d]));
        end
    endtask

    int exp_rr [5] = '{0, 1, 2, 3, 0};
    logic [31:0] abcd [4] = '{32'hA, 32'hB, 32'hC, 32'hD};

    initial begin
        model_reset();
        din = {32'hD, 32'hC, 32'hB, 32'hA};
        @(negedge clk);

        for (int i = 0; i < 3; i++) step(4'hF, 1'b0, 2'd0, 1'b1);
        check("rst_fp_data", 64'(if_fp.out_data), 64'd0);
        check("rst_rr_valid", 64'(if_rr.out_valid), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step(4'hF, 1'b0, 2'd0, 1'b1);
            check("rr_seq_sel", 64'(if_rr.out_sel), 64'(exp_rr[i]));
            check("rr_seq_data", 64'(if_rr.out_data), 64'(abcd[exp_rr[i]]));
            check("fp_prio_data", 64'(if_fp.out_data), 64'h0A);
        end
        for (int i = 0; i < 3; i++) begin
            step(4'b0100, 1'b0, 2'd0, 1'b1);
            check("rr_only2_sel", 64'(if_rr.out_sel), 64'd2);
        end

        step(4'b0010, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'hF, 1'b0, 2'd0, 1'b0);
            check("stall_data", 64'(if_rr.out_data), 64'h0B);
        end
        step(4'b1000, 1'b0, 2'd0, 1'b1);
        check("unstall_data", 64'(if_rr.out_data), 64'h0D);
        check("unstall_valid", 64'(if_rr.out_valid), 64'd1);

        for (int i = 0; i < 4; i++) begin
            step(4'hF, 1'b1, 2'd2, 1'b1);
            check("force_rr_sel", 64'(if_rr.out_sel), 64'd2);
            check("force_fp_sel", 64'(if_fp.out_sel), 64'd2);
        end
        step(4'hF, 1'b0, 2'd0, 1'b1);
        check("force_ptr_kept", 64'(if_rr.out_sel), 64'd0);
        step(4'b1011, 1'b1, 2'd2, 1'b1);
        check("force_nogrant", 64'(if_rr.out_valid), 64'd0);

        step(4'hF, 1'b0, 2'd0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(if_rr.out_valid), 64'd0);
        check("async_rst_data", 64'(if_fp.out_data), 64'd0);
        model_reset();
        @(negedge clk);
        step(4'hF, 1'b0, 2'd0, 1'b1);
        rst_n = 1'b1;
        step(4'hF, 1'b0, 2'd0, 1'b1);
        check("rst_rr_restart", 64'(if_rr.out_sel), 64'd0);

        for (int i = 0; i < 600; i++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            step(4'($urandom), ($urandom % 4) == 0, 2'($urandom),
                 ($urandom % 4) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
